// File: rtl/posit_defines_pkg.sv
// Shared posit<32,2> widths, constants and the decoded-value payload.
package posit_defines;

    localparam int unsigned NBITS   = 32;
    localparam int unsigned ES      = 2;
    localparam int unsigned FBITS   = NBITS - 3 - ES;
    localparam int unsigned SCALE_W = 9;
    localparam int unsigned RUN_W   = 5;
    localparam int unsigned K_W     = SCALE_W - ES;

    localparam logic [NBITS-1:0] NAR = 32'h8000_0000;

    typedef struct packed {
        logic               sign;
        logic [SCALE_W-1:0] scale;
        logic [FBITS-1:0]   fraction;
        logic               zero;
        logic               inf;
    } posit_value_t;

endpackage

// File: rtl/posit_regime_count.sv
// Combinational regime run-length counter over the 31 magnitude bits below the sign.
module posit_regime_count
    import posit_defines::*;
(
    input  logic [NBITS-2:0] mag_i,
    output logic [RUN_W-1:0] run_o,
    output logic             pol_o
);

    logic [NBITS-2:0] flip;
    logic             found;

    // Run length = leading-zero count of the magnitude with the regime polarity folded out.
    always_comb begin
        pol_o = mag_i[NBITS-2];
        flip  = pol_o ? ~mag_i : mag_i;
        run_o = RUN_W'(NBITS - 1);
        found = 1'b0;
        for (int i = NBITS - 2; i >= 0; i--) begin
            if (!found && flip[i]) begin
                run_o = RUN_W'(NBITS - 2 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_decode_stream.sv
// Three-stage flow-controlled posit<32,2> unpacker: S0 capture, S1 regime count, S2 field extract.
module posit_decode_stream
    import posit_defines::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output posit_value_t       out_value,
    output logic               busy
);

    logic             s0_valid_q, s0_valid_d;
    logic             s0_sign_q,  s0_sign_d;
    logic             s0_zero_q,  s0_zero_d;
    logic             s0_inf_q,   s0_inf_d;
    logic [NBITS-2:0] s0_mag_q,   s0_mag_d;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q,  s1_sign_d;
    logic             s1_zero_q,  s1_zero_d;
    logic             s1_inf_q,   s1_inf_d;
    logic             s1_pol_q,   s1_pol_d;
    logic [RUN_W-1:0] s1_run_q,   s1_run_d;
    logic [NBITS-2:0] s1_mag_q,   s1_mag_d;

    logic             s2_valid_q, s2_valid_d;
    posit_value_t     s2_value_q, s2_value_d;
    logic             busy_q;

    logic             adv0, adv1, adv2;
    logic [RUN_W-1:0] run_c;
    logic             pol_c;
    logic [RUN_W:0]   shamt;
    logic [NBITS-4:0] rest;
    logic [K_W-1:0]   k_c;
    posit_value_t     value_c;

    // Stall chain: a stage moves when it is empty or its successor moves.
    assign adv2     = ~s2_valid_q | out_ready;
    assign adv1     = ~s1_valid_q | adv2;
    assign adv0     = ~s0_valid_q | adv1;
    assign in_ready = adv0;

    assign out_valid = s2_valid_q;
    assign out_value = s2_value_q;
    assign busy      = busy_q;

    posit_regime_count u_regime (
        .mag_i (s0_mag_q),
        .run_o (run_c),
        .pol_o (pol_c)
    );

    // Strip regime + terminator, then split the remainder into exponent and fraction.
    always_comb begin
        shamt   = {1'b0, s1_run_q} + (RUN_W+1)'(1);
        rest    = (NBITS-3)'((s1_mag_q << shamt) >> ES);
        k_c     = s1_pol_q ? (K_W'(s1_run_q) - K_W'(1)) : (K_W'(0) - K_W'(s1_run_q));
        value_c = '0;
        if (s1_zero_q) begin
            value_c.zero = 1'b1;
        end else if (s1_inf_q) begin
            value_c.inf  = 1'b1;
            value_c.sign = 1'b1;
        end else begin
            value_c.sign     = s1_sign_q;
            value_c.scale    = {k_c, rest[NBITS-4 -: ES]};
            value_c.fraction = rest[FBITS-1:0];
        end
    end

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_sign_d  = s0_sign_q;
        s0_zero_d  = s0_zero_q;
        s0_inf_d   = s0_inf_q;
        s0_mag_d   = s0_mag_q;
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_inf_d   = s1_inf_q;
        s1_pol_d   = s1_pol_q;
        s1_run_d   = s1_run_q;
        s1_mag_d   = s1_mag_q;
        s2_valid_d = s2_valid_q;
        s2_value_d = s2_value_q;

        if (adv0) begin
            s0_valid_d = in_valid;
            if (in_valid) begin
                s0_sign_d = in_data[NBITS-1];
                s0_zero_d = (in_data == '0);
                s0_inf_d  = (in_data == NAR);
                s0_mag_d  = (NBITS-1)'(in_data[NBITS-1] ? (NBITS'(0) - in_data) : in_data);
            end
        end
        if (adv1) begin
            s1_valid_d = s0_valid_q;
            if (s0_valid_q) begin
                s1_sign_d = s0_sign_q;
                s1_zero_d = s0_zero_q;
                s1_inf_d  = s0_inf_q;
                s1_pol_d  = pol_c;
                s1_run_d  = run_c;
                s1_mag_d  = s0_mag_q;
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_value_d = value_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_value_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_value_q <= s2_value_d;
            busy_q     <= s0_valid_d | s1_valid_d | s2_valid_d;
        end
    end

    // Payload registers are qualified by the valids and need no reset.
    always_ff @(posedge clk) begin
        s0_sign_q <= s0_sign_d;
        s0_zero_q <= s0_zero_d;
        s0_inf_q  <= s0_inf_d;
        s0_mag_q  <= s0_mag_d;
        s1_sign_q <= s1_sign_d;
        s1_zero_q <= s1_zero_d;
        s1_inf_q  <= s1_inf_d;
        s1_pol_q  <= s1_pol_d;
        s1_run_q  <= s1_run_d;
        s1_mag_q  <= s1_mag_d;
    end

endmodule

// File: tb/tb_posit_decode_stream.sv
// Directed-table and random-stream bench for posit_decode_stream.
module tb_posit_decode_stream;
    import posit_defines::*;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    posit_value_t out_value;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  data;
        posit_value_t exp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    posit_decode_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic posit_value_t mk(input logic s, input logic [8:0] sc,
                                        input logic [26:0] fr, input logic z, input logic i);
        posit_value_t v;
        v.sign = s; v.scale = sc; v.fraction = fr; v.zero = z; v.inf = i;
        return v;
    endfunction

    // Independent re-encoder: rebuilds the posit word from a decoded value.
    function automatic logic [31:0] encode(input posit_value_t v);
        logic [30:0] body;
        int p;
        int k;
        if (v.zero) return 32'h0;
        if (v.inf)  return 32'h8000_0000;
        k = int'($signed(v.scale)) >>> 2;
        body = '0;
        p = 30;
        if (k >= 0) begin
            for (int i = 0; i <= k; i++) begin
                if (p >= 0) body[p] = 1'b1;
                p--;
            end
            if (p >= 0) body[p] = 1'b0;
            p--;
        end else begin
            for (int i = 0; i < -k; i++) begin
                if (p >= 0) body[p] = 1'b0;
                p--;
            end
            if (p >= 0) body[p] = 1'b1;
            p--;
        end
        for (int i = 1; i >= 0; i--) begin
            if (p >= 0) body[p] = v.scale[i];
            p--;
        end
        for (int i = 26; i >= 0; i--) begin
            if (p >= 0) body[p] = v.fraction[i];
            p--;
        end
        return v.sign ? (32'd0 - {1'b0, body}) : {1'b0, body};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word with out_ready=1 and wait (bounded) for its result.
    task automatic send_one(input logic [31:0] d, output posit_value_t v, output int lat);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        v = out_value;
    endtask

    initial begin
        posit_value_t v;
        int lat;
        int sent, recv, cnt, cyc;
        bit fire_in, fire_out, hold;
        logic [31:0] q[$];
        logic [31:0] expw;
        bit pat[4];

        vecs[0]  = '{32'h4000_0000, mk(1'b0, 9'h000, 27'h0,       1'b0, 1'b0)};
        vecs[1]  = '{32'hC000_0000, mk(1'b1, 9'h000, 27'h0,       1'b0, 1'b0)};
        vecs[2]  = '{32'h4800_0000, mk(1'b0, 9'h001, 27'h0,       1'b0, 1'b0)};
        vecs[3]  = '{32'h4C00_0000, mk(1'b0, 9'h001, 27'h4000000, 1'b0, 1'b0)};
        vecs[4]  = '{32'h7FFF_FFFF, mk(1'b0, 9'h078, 27'h0,       1'b0, 1'b0)};
        vecs[5]  = '{32'h0000_0001, mk(1'b0, 9'h188, 27'h0,       1'b0, 1'b0)};
        vecs[6]  = '{32'h0000_0000, mk(1'b0, 9'h000, 27'h0,       1'b1, 1'b0)};
        vecs[7]  = '{32'h8000_0000, mk(1'b1, 9'h000, 27'h0,       1'b0, 1'b1)};
        vecs[8]  = '{32'h2000_0000, mk(1'b0, 9'h1FC, 27'h0,       1'b0, 1'b0)};
        vecs[9]  = '{32'h6000_0000, mk(1'b0, 9'h004, 27'h0,       1'b0, 1'b0)};
        vecs[10] = '{32'h7FFF_FFFE, mk(1'b0, 9'h074, 27'h0,       1'b0, 1'b0)};
        vecs[11] = '{32'hFFFF_FFFF, mk(1'b1, 9'h188, 27'h0,       1'b0, 1'b0)};
        vecs[12] = '{32'h4300_0000, mk(1'b0, 9'h000, 27'h3000000, 1'b0, 1'b0)};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_value", 64'(out_value), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0;
        tick();

        // Directed table, one word at a time.
        for (int i = 0; i < NVEC; i++) begin
            send_one(vecs[i].data, v, lat);
            chk($sformatf("latency_%0d", i), 64'(lat), 64'd3);
            chk($sformatf("value_%08h", vecs[i].data), 64'(v), 64'(vecs[i].exp));
        end
        tick();

        // Backpressure stream: out_ready pattern 1,0,0,1.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        sent = 0; recv = 0; cnt = 0; cyc = 0;
        while (recv < 8 && cyc < 200) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 8);
            in_data   = vecs[(sent < 8) ? sent : 0].data;
            #3;
            chk("bp_in_ready", 64'(in_ready), 64'(!(cnt == 3 && !out_ready)));
            chk("bp_busy",     64'(busy),     64'(cnt != 0));
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                chk($sformatf("bp_out_%0d", recv), 64'(out_value), 64'(vecs[recv].exp));
                recv++;
            end
            if (fire_in) sent++;
            cnt = cnt + int'(fire_in) - int'(fire_out);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_all_received", 64'(recv), 64'd8);
        out_ready = 1'b1;
        repeat (4) tick();

        // Reset with three words in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vecs[2 + i].data;
            tick();
        end
        in_valid = 1'b0;
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_in_ready",  64'(in_ready),  64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        in_data   = 32'h4800_0000;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_c1", 64'(out_valid), 64'd0);
        tick();
        chk("post_rst_c2", 64'(out_valid), 64'd0);
        tick();
        chk("post_rst_c3", 64'(out_valid), 64'd1);
        chk("post_rst_val", 64'(out_value), 64'(vecs[2].exp));
        tick();

        // Random stream checked by re-encoding against the input order.
        sent = 0; recv = 0; cyc = 0; hold = 1'b0;
        while (recv < 10000 && cyc < 60000) begin
            if (!hold) begin
                in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 15))
                    0:       in_data = 32'h0;
                    1:       in_data = 32'h8000_0000;
                    2:       in_data = $urandom & 32'h8000_00FF;
                    3:       in_data = $urandom | 32'h7FFF_FF00;
                    default: in_data = $urandom;
                endcase
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_out", 64'(out_value), 64'd0);
                    errors += (out_value == '0) ? 1 : 0;
                end else begin
                    expw = q.pop_front();
                    chk($sformatf("rand_%0d", recv), 64'(encode(out_value)), 64'(expw));
                end
                recv++;
            end
            if (fire_in) begin
                q.push_back(in_data);
                sent++;
            end
            hold = in_valid && !fire_in;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_all_received", 64'(recv), 64'd10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
